// File: rtl/boot_loader_if.sv
// Boot-port bundle: byte-stream handshake in, instruction-memory write port out.
// The loader drives the master side; the CPU top / byte source sits on the slave side.
interface boot_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              boot_up;
  logic [ADDR_W-1:0] boot_addr;
  logic [DATA_W-1:0] boot_datai;
  logic              boot_web;

  modport master (
    input  in_valid, in_data,
    output in_ready, boot_up, boot_addr, boot_datai, boot_web
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, boot_up, boot_addr, boot_datai, boot_web
  );
endinterface

// File: rtl/boot_loader.sv
// Packs a byte stream (first byte most significant) into 32-bit words and writes
// them to consecutive icache addresses from 0, holding the CPU in boot mode meanwhile.
module boot_loader #(
  parameter int BOOT_WORDS = 32,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  boot_loader_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, ASSEMBLE, WRITE, FINISH} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(BOOT_WORDS - 1);

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [DATA_W-1:0] shift_word;
  logic [DATA_W-1:0] next_word;
  logic              take_byte;

  always_comb begin
    next_word = {shift_word[DATA_W-9:0], bus.in_data};
    take_byte = (state == ASSEMBLE) && bus.in_valid && bus.in_ready;
  end

  // Assembly register is pure data: no reset, partial words are simply overwritten.
  always_ff @(posedge clk) begin
    if (take_byte) shift_word <= next_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      word_cnt       <= '0;
      bus.in_ready   <= 1'b0;
      bus.boot_up    <= 1'b0;
      bus.boot_web   <= 1'b1;
      bus.boot_addr  <= '0;
      bus.boot_datai <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      checksum       <= '0;
    end else begin
      done <= 1'b0;
      // A write already issued this cycle still lands; only the rest of the load is dropped.
      if (abort && (state == ASSEMBLE || state == WRITE)) begin
        state          <= IDLE;
        bus.in_ready   <= 1'b0;
        bus.boot_up    <= 1'b0;
        bus.boot_web   <= 1'b1;
        bus.boot_addr  <= '0;
        bus.boot_datai <= '0;
        busy           <= 1'b0;
        aborted        <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state        <= ASSEMBLE;
              bus.boot_up  <= 1'b1;
              bus.in_ready <= 1'b1;
              busy         <= 1'b1;
              aborted      <= 1'b0;
              checksum     <= '0;
              byte_cnt     <= '0;
              word_cnt     <= '0;
            end
          end
          ASSEMBLE: begin
            if (take_byte) begin
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                state          <= WRITE;
                bus.in_ready   <= 1'b0;
                bus.boot_web   <= 1'b0;
                bus.boot_addr  <= word_cnt;
                bus.boot_datai <= next_word;
                checksum       <= checksum ^ next_word;
              end
            end
          end
          WRITE: begin
            bus.boot_web <= 1'b1;
            word_cnt     <= word_cnt + 1'b1;
            if (word_cnt == LAST_WORD) begin
              state          <= FINISH;
              bus.boot_up    <= 1'b0;
              bus.boot_addr  <= '0;
              bus.boot_datai <= '0;
              done           <= 1'b1;
            end else begin
              state        <= ASSEMBLE;
              bus.in_ready <= 1'b1;
            end
          end
          FINISH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: drives byte streams and compares the observed icache
// writes against words packed straight from the byte list.
module tb_boot_loader;
  localparam int NW = 32;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, aborted;
  logic [DW-1:0] checksum;

  boot_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  boot_loader #(.BOOT_WORDS(NW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
    .busy(busy), .done(done), .aborted(aborted), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation log
  int            cyc = 0;
  int            acc_cyc[$];
  int            wr_cyc[$];
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int            done_cnt = 0, done_bad = 0, adj_cnt = 0;
  logic          prev_web = 1'b1, prev_up = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
    if (bus.boot_web === 1'b0) begin
      wr_addr.push_back(bus.boot_addr);
      wr_data.push_back(bus.boot_datai);
      wr_cyc.push_back(cyc);
      if (!prev_web) adj_cnt <= adj_cnt + 1;
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      if (bus.boot_up !== 1'b0 || prev_up !== 1'b1) done_bad <= done_bad + 1;
    end
    prev_web <= (bus.boot_web === 1'b0) ? 1'b0 : 1'b1;
    prev_up  <= bus.boot_up;
  end

  // Reference: word j is bytes 4j..4j+3, first byte in the top lane.
  function automatic logic [31:0] word_of(input logic [7:0] b[$], input int j);
    return {b[4*j], b[4*j+1], b[4*j+2], b[4*j+3]};
  endfunction

  function automatic logic [31:0] xor_of(input logic [7:0] b[$], input int n);
    logic [31:0] x = '0;
    for (int j = 0; j < n; j++) x ^= word_of(b, j);
    return x;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: every other cycle + 10-cycle gap mid-word, 2: random gaps
  task automatic load(input logic [7:0] b[$], input int mode, input int start_at, inout int to);
    bit ok;
    for (int i = 0; i < b.size(); i++) begin
      if (i == start_at) pulse_start();
      if (mode == 1 && i == 42) idle(10);
      send_byte(b[i], ok);
      if (!ok) to++;
      if (mode == 1) idle(1);
      else if (mode == 2) idle($urandom_range(0, 2));
    end
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (done_cnt > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom);
      start        = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    n_checks++; if (bus.boot_web !== 1'b1) begin n_fail++; $display("FAIL reset boot_web: got %b expected 1", bus.boot_web); end
    n_checks++; if (bus.boot_up !== 1'b0) begin n_fail++; $display("FAIL reset boot_up: got %b expected 0", bus.boot_up); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b expected 0", bus.in_ready); end
    n_checks++; if ({busy, done, aborted} !== 3'b000) begin n_fail++; $display("FAIL reset busy/done/aborted: got %b expected 000", {busy, done, aborted}); end
    n_checks++; if (checksum !== '0) begin n_fail++; $display("FAIL reset checksum: got %h expected 0", checksum); end
    n_checks++; if (bus.boot_addr !== '0 || bus.boot_datai !== '0) begin n_fail++; $display("FAIL reset addr/data: got %h/%h expected 0/0", bus.boot_addr, bus.boot_datai); end
    rst = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
    idle(2);
  endtask

  task automatic test_stream(input int mode, input string tag);
    logic [7:0] q[$];
    int  wb = wr_addr.size(), ab = acc_cyc.size(), db = done_cnt, adjb = adj_cnt, badb = done_bad;
    int  to = 0, nw;
    bit  ok;
    for (int i = 0; i < 4*NW; i++) q.push_back((mode == 2) ? 8'($urandom) : 8'(i));
    pulse_start();
    load(q, mode, -1, to);
    wait_done(db, ok);
    nw = wr_addr.size() - wb;
    n_checks++; if (to != 0 || !ok) begin n_fail++; $display("FAIL %s handshake/done timeout: got %0d/%0d expected 0/1", tag, to, ok); end
    n_checks++; if (nw != NW) begin n_fail++; $display("FAIL %s write count: got %0d expected %0d", tag, nw, NW); end
    n_checks++; if (acc_cyc.size() - ab != 4*NW) begin n_fail++; $display("FAIL %s bytes accepted: got %0d expected %0d", tag, acc_cyc.size() - ab, 4*NW); end
    for (int j = 0; j < NW && j < nw; j++) begin
      n_checks++; if (wr_addr[wb+j] !== AW'(j)) begin n_fail++; $display("FAIL %s addr[%0d]: got %0d expected %0d", tag, j, wr_addr[wb+j], j); end
      n_checks++; if (wr_data[wb+j] !== word_of(q, j)) begin n_fail++; $display("FAIL %s data[%0d]: got %h expected %h", tag, j, wr_data[wb+j], word_of(q, j)); end
      n_checks++; if (wr_cyc[wb+j] != acc_cyc[ab+4*j+3] + 1) begin n_fail++; $display("FAIL %s write latency[%0d]: got cycle %0d expected %0d", tag, j, wr_cyc[wb+j], acc_cyc[ab+4*j+3] + 1); end
    end
    if (mode != 2 && nw > 1) begin
      n_checks++; if (wr_data[wb+1] !== 32'h04050607) begin n_fail++; $display("FAIL %s addr1 word: got %h expected 04050607", tag, wr_data[wb+1]); end
    end
    n_checks++; if (done_cnt - db != 1) begin n_fail++; $display("FAIL %s done pulses: got %0d expected 1", tag, done_cnt - db); end
    n_checks++; if (done_bad != badb) begin n_fail++; $display("FAIL %s done not aligned with boot_up fall: got %0d expected 0", tag, done_bad - badb); end
    n_checks++; if (adj_cnt != adjb) begin n_fail++; $display("FAIL %s adjacent boot_web pulses: got %0d expected 0", tag, adj_cnt - adjb); end
    n_checks++; if (checksum !== xor_of(q, NW)) begin n_fail++; $display("FAIL %s checksum: got %h expected %h", tag, checksum, xor_of(q, NW)); end
    n_checks++; if (busy !== 1'b0 || bus.boot_up !== 1'b0) begin n_fail++; $display("FAIL %s end busy/boot_up: got %b%b expected 00", tag, busy, bus.boot_up); end
    idle(3);
  endtask

  task automatic test_start_busy();
    logic [7:0] q[$];
    int  wb = wr_addr.size(), db = done_cnt, to = 0, nw;
    for (int i = 0; i < 4*NW; i++) q.push_back(8'($urandom));
    pulse_start();
    load(q, 0, 21, to);
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL start_busy finish cycle done: got %b expected 1", done); end
    pulse_start();
    idle(3);
    nw = wr_addr.size() - wb;
    n_checks++; if (to != 0 || nw != NW) begin n_fail++; $display("FAIL start_busy writes/timeouts: got %0d/%0d expected %0d/0", nw, to, NW); end
    for (int j = 0; j < NW && j < nw; j++) begin
      n_checks++; if (wr_addr[wb+j] !== AW'(j) || wr_data[wb+j] !== word_of(q, j)) begin n_fail++; $display("FAIL start_busy write[%0d]: got %0d:%h expected %0d:%h", j, wr_addr[wb+j], wr_data[wb+j], j, word_of(q, j)); end
    end
    n_checks++; if (done_cnt - db != 1) begin n_fail++; $display("FAIL start_busy done pulses: got %0d expected 1", done_cnt - db); end
    n_checks++; if (busy !== 1'b0 || bus.boot_up !== 1'b0) begin n_fail++; $display("FAIL start_busy restarted after finish: busy/boot_up got %b%b expected 00", busy, bus.boot_up); end
  endtask

  task automatic test_abort();
    logic [7:0] q[$], q2[$];
    int  wb = wr_addr.size(), db = done_cnt, to = 0, nw;
    bit  ok;
    for (int i = 0; i < 10; i++) q.push_back(8'($urandom));
    for (int i = 0; i < 4*NW; i++) q2.push_back(8'($urandom));
    pulse_start();
    load(q, 0, -1, to);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++; if (bus.boot_up !== 1'b0 || aborted !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL abort state boot_up/aborted/busy: got %b%b%b expected 010", bus.boot_up, aborted, busy); end
    n_checks++; if (bus.in_ready !== 1'b0 || bus.boot_web !== 1'b1) begin n_fail++; $display("FAIL abort in_ready/boot_web: got %b%b expected 01", bus.in_ready, bus.boot_web); end
    idle(10);
    nw = wr_addr.size() - wb;
    n_checks++; if (nw != 2 || to != 0) begin n_fail++; $display("FAIL abort write count: got %0d expected 2", nw); end
    for (int j = 0; j < 2 && j < nw; j++) begin
      n_checks++; if (wr_addr[wb+j] !== AW'(j) || wr_data[wb+j] !== word_of(q, j)) begin n_fail++; $display("FAIL abort write[%0d]: got %0d:%h expected %0d:%h", j, wr_addr[wb+j], wr_data[wb+j], j, word_of(q, j)); end
    end
    n_checks++; if (done_cnt != db) begin n_fail++; $display("FAIL abort done pulses: got %0d expected 0", done_cnt - db); end
    n_checks++; if (checksum !== (word_of(q, 0) ^ word_of(q, 1))) begin n_fail++; $display("FAIL abort checksum: got %h expected %h", checksum, word_of(q, 0) ^ word_of(q, 1)); end
    wb = wr_addr.size();
    pulse_start();
    n_checks++; if (aborted !== 1'b0 || checksum !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart aborted/checksum/busy: got %b/%h/%b expected 0/0/1", aborted, checksum, busy); end
    load(q2, 0, -1, to);
    wait_done(db, ok);
    nw = wr_addr.size() - wb;
    n_checks++; if (!ok || nw != NW) begin n_fail++; $display("FAIL restart writes/done: got %0d/%0d expected %0d/1", nw, ok, NW); end
    n_checks++; if (nw > 0 && (wr_addr[wb] !== '0 || wr_data[wb] !== word_of(q2, 0))) begin n_fail++; $display("FAIL restart first write: got %0d:%h expected 0:%h", wr_addr[wb], wr_data[wb], word_of(q2, 0)); end
    n_checks++; if (checksum !== xor_of(q2, NW)) begin n_fail++; $display("FAIL restart checksum: got %h expected %h", checksum, xor_of(q2, NW)); end
    idle(3);
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    int  wb = wr_addr.size(), ab = acc_cyc.size(), to = 0;
    for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
    pulse_start();
    load(q, 0, -1, to);
    n_checks++; if (bus.boot_web !== 1'b0 || bus.boot_addr !== AW'(3)) begin n_fail++; $display("FAIL reset_mid word3 write: got web %b addr %0d expected 0 3", bus.boot_web, bus.boot_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (bus.boot_web !== 1'b1 || bus.boot_up !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid web/up/busy: got %b%b%b expected 100", bus.boot_web, bus.boot_up, busy); end
    n_checks++; if (bus.in_ready !== 1'b0 || checksum !== '0) begin n_fail++; $display("FAIL reset_mid in_ready/checksum: got %b/%h expected 0/0", bus.in_ready, checksum); end
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin bus.in_data = 8'($urandom); idle(1); end
    bus.in_valid = 1'b0;
    n_checks++; if (wr_addr.size() - wb != 4 || to != 0) begin n_fail++; $display("FAIL reset_mid writes: got %0d expected 4", wr_addr.size() - wb); end
    n_checks++; if (acc_cyc.size() - ab != 16) begin n_fail++; $display("FAIL reset_mid bytes consumed: got %0d expected 16", acc_cyc.size() - ab); end
    idle(2);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1;
    test_reset();
    test_stream(0, "full_load");
    test_stream(1, "bursty");
    test_start_busy();
    test_abort();
    test_reset_mid();
    test_stream(2, "random_stream");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Master side of the CPU top's instruction-memory boot port (boot_up / boot_addr / boot_datai / boot_web).
- Accepts a byte stream over a valid/ready handshake and assembles it into 32-bit words, first byte most significant.
- Writes each word to consecutive icache addresses starting at 0. After BOOT_WORDS words it releases boot_up so the CPU leaves boot mode and starts fetching.

Parameters:
BOOT_WORDS, 32, number of instruction words loaded per boot (1..256)
ADDR_W, 8, width of boot_addr
DATA_W, 32, width of boot_datai; fixed at 4 bytes

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle pulse; begins a boot sequence when idle
abort  input  1  single-cycle pulse; terminates an in-progress boot
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  byte accepted on a cycle where in_valid&&in_ready
boot_up  output  1  holds the CPU in boot mode
boot_addr  output  ADDR_W  icache write address
boot_datai  output  DATA_W  icache write data
boot_web  output  1  icache write enable, active low
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on successful completion
aborted  output  1  sticky; set by abort, cleared by the next accepted start
checksum  output  DATA_W  XOR of all words written in the current or last boot

Behaviour:
- Interface: one clock domain, clk. Reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: boot_up=0, boot_web=1, boot_addr=0, boot_datai=0, in_ready=0, busy=0, done=0, aborted=0, checksum=0.
- Internal state: 2-bit byte counter, word counter, 32-bit assembly register.
- FSM states: IDLE, ASSEMBLE, WRITE, FINISH.
- IDLE
  - start=1 → ASSEMBLE on the next edge.
  - On that edge: boot_up=1, busy=1, aborted=0, checksum=0, byte counter=0, word counter=0.
- ASSEMBLE
  - in_ready=1.
  - Each accepted byte shifts in: asm <= {asm[23:0], in_data}.
  - The byte counter wraps 3→0.
  - Acceptance of the 4th byte at edge N → WRITE. Registered outputs for cycle N+1: in_ready=0, boot_web=0, boot_addr=word counter, boot_datai=assembled word, checksum ^= word.
  - in_valid low stalls indefinitely with no side effects.
- WRITE
  - Lasts exactly one cycle, with boot_web=0 for that cycle only.
  - On exit: boot_web=1, word counter increments.
  - If the word just written was index BOOT_WORDS-1 → FINISH. Otherwise → ASSEMBLE with in_ready=1.
  - boot_addr and boot_datai hold their values between writes.
- FINISH
  - One cycle with boot_up=0, boot_web=1, boot_addr=0, boot_datai=0, done=1, in_ready=0.
  - Then → IDLE; done and busy return to 0.
- Minimum gap between writes: 4 cycles (4 bytes, 1 byte per cycle). boot_web pulses are never adjacent.
- start while busy (including the FINISH cycle) is ignored.
- abort in ASSEMBLE or WRITE:
  - Next edge: IDLE, boot_up=0, boot_web=1, boot_addr=0, boot_datai=0, in_ready=0, aborted=1, done=0.
  - Any partial word is discarded.
  - If abort arrives during WRITE, that write still occurred (boot_web was already low that cycle).
  - abort in IDLE or FINISH is ignored; FINISH completes normally.
- start and abort together in IDLE: start wins.
- rst mid-operation: all outputs and state return to reset values on the next edge; no further writes.
- in_data beyond BOOT_WORDS*4 bytes is not consumed (in_ready=0 outside ASSEMBLE).

Test Plan:
1. Reset
   - Stimulus: hold rst=1 for 2 cycles, with random in_valid/start.
   - Required: boot_web=1, boot_up=0, in_ready=0, busy=0, done=0, checksum=0.
2. Full load, continuous stream
   - Stimulus: start pulse, then bytes 0x00..0x7F presented back-to-back.
   - Required: exactly 32 single-cycle boot_web=0 pulses at addr 0..31.
   - Word j = {4j, 4j+1, 4j+2, 4j+3}; e.g. addr 1 = 0x04050607.
   - Each write appears the cycle after its 4th byte.
   - done=1 in the same cycle boot_up falls; checksum = XOR of all 32 words.
3. Bursty stream
   - Stimulus: same bytes with in_valid toggled every other cycle, plus a 10-cycle gap mid-word.
   - Required: identical writes and checksum as scenario 2; no extra or duplicated writes.
4. Start while busy
   - Stimulus: a second start pulse during word 5 and another during FINISH.
   - Required: ignored; addresses continue 6..31 and exactly one done pulse.
5. Abort mid-load
   - Stimulus: abort after 10 bytes.
   - Required: only addr 0,1 written; next cycle boot_up=0, aborted=1, done never pulses.
   - A following start clears aborted and restarts at addr 0 with checksum reset.
6. Reset mid-load
   - Stimulus: rst=1 one cycle during the WRITE of word 3.
   - Required: next edge boot_web=1, boot_up=0, busy=0; no writes until a new start.
